// File: rtl/data_memory.sv
// data_memory: block-organised RAM with combinational word/block read and whole-block write
// Ports: ptr word address, in_block write data, out_data word at ptr, out_block block holding ptr,
//        clk rising-edge clock, write_enable whole-block write strobe, rst_n async active-low clear.
module data_memory #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_BLOCKS = 1024
) (
  input  logic [WORD_SIZE-1:0]            ptr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] in_block,
  output logic [WORD_SIZE-1:0]            out_data,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] out_block,
  input  logic                            clk,
  input  logic                            write_enable,
  input  logic                            rst_n
);
  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int BLK_W = WORD_SIZE * BLOCK_SIZE;
  logic [BLK_W-1:0] mem_q [MEM_BLOCKS];
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic             unused_hi;
  // address bits above the block index alias onto the same block
  assign unused_hi = ^ptr[WORD_SIZE-1:OFF_W+IDX_W];
  always_comb begin
    off       = ptr[OFF_W-1:0];
    idx       = ptr[OFF_W+IDX_W-1:OFF_W];
    out_block = mem_q[idx];
    // offset 0 is the most significant word of the block
    out_data  = out_block[(BLOCK_SIZE-1-int'(off))*WORD_SIZE +: WORD_SIZE];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < MEM_BLOCKS; i++) mem_q[i] <= '0;
    else if (write_enable)
      mem_q[idx] <= in_block;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory with directed vectors
module tb_data_memory;
  localparam int BW = 512;
  logic [31:0]   ptr;
  logic [BW-1:0] in_block;
  logic [31:0]   out_data;
  logic [BW-1:0] out_block;
  logic          clk, write_enable, rst_n;
  typedef struct {
    string         name;
    logic [31:0]   d;
    logic [BW-1:0] b;
    bit            cb;
  } exp_t;
  exp_t q[$];
  event smp;
  int n_vec, n_bad;
  logic [BW-1:0] blk_a, blk_b, blk_x;
  data_memory dut (
    .ptr(ptr), .in_block(in_block), .out_data(out_data), .out_block(out_block),
    .clk(clk), .write_enable(write_enable), .rst_n(rst_n)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // monitor: pops expected responses and compares when a sample is presented
  initial begin
    exp_t e;
    forever begin
      @(smp);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (out_data !== e.d || (e.cb && out_block !== e.b)) begin
          n_bad++;
          $display("FAIL %s: out_data=%h want %h out_block=%h want %h", e.name, out_data, e.d,
                   out_block, e.cb ? e.b : out_block);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] p, input logic [31:0] d,
                     input logic [BW-1:0] b, input bit cb);
    ptr = p;
    #1;
    q.push_back('{n, d, b, cb});
    -> smp;
    #1;
  endtask
  task automatic wr(input logic [31:0] p, input logic [BW-1:0] blk);
    @(negedge clk);
    ptr = p; in_block = blk; write_enable = 1;
    @(negedge clk);
    write_enable = 0;
  endtask
  // word k shifted in last ends up lowest, so word 0 lands in the MSB position
  function automatic logic [BW-1:0] mk(input logic [31:0] base);
    logic [BW-1:0] r = '0;
    for (int k = 0; k < 16; k++) r = {r[BW-33:0], base + 32'(k)};
    return r;
  endfunction
  initial begin
    n_vec = 0; n_bad = 0;
    ptr = 32'h0000_0123; in_block = '0; write_enable = 0; rst_n = 1;
    blk_a = mk(32'h1000_0000);
    blk_b = mk(32'hB000_0000);
    blk_x = {16{32'hAAAA_AAAA}};
    #2 rst_n = 0;
    #1;
    chk("reset", 32'h0000_0123, 32'h0, '0, 1);
    @(negedge clk); rst_n = 1;
    // read-during-write: old contents before the edge, new right after
    @(negedge clk);
    ptr = 32'h40; in_block = blk_a; write_enable = 1;
    chk("rdw_before", 32'h40, 32'h0, '0, 1);
    @(posedge clk); #1;
    chk("rdw_after", 32'h40, 32'h1000_0000, blk_a, 1);
    @(negedge clk); write_enable = 0;
    for (int k = 0; k < 16; k++)
      chk($sformatf("blk_rd_%0d", k), 32'h40 + 32'(k), 32'h1000_0000 + 32'(k), blk_a, 1);
    // enable low leaves storage unchanged
    @(negedge clk); ptr = 32'h40; in_block = ~blk_a; write_enable = 0;
    repeat (3) @(negedge clk);
    chk("en_low_0", 32'h40, 32'h1000_0000, blk_a, 1);
    chk("en_low_f", 32'h4F, 32'h1000_000F, blk_a, 0);
    // aliasing through ignored upper address bits
    wr(32'h0000_4010, blk_x);
    chk("alias_lo", 32'h0000_0010, 32'hAAAA_AAAA, blk_x, 1);
    chk("alias_hi", 32'hFFFF_C01F, 32'hAAAA_AAAA, blk_x, 0);
    chk("alias_keep", 32'h45, 32'h1000_0005, blk_a, 0);
    // back-to-back writes to index 5, last wins
    @(negedge clk); ptr = 32'h50; in_block = {16{32'h1111_1111}}; write_enable = 1;
    @(negedge clk); in_block = blk_b;
    @(negedge clk); write_enable = 0;
    chk("b2b_0", 32'h50, 32'hB000_0000, blk_b, 1);
    chk("b2b_f", 32'h5F, 32'hB000_000F, blk_b, 0);
    chk("b2b_idx6", 32'h60, 32'h0, '0, 1);
    // asynchronous reset between edges clears before the next edge
    @(posedge clk); #2;
    ptr = 32'h41;
    rst_n = 0;
    chk("async_rst", 32'h41, 32'h0, '0, 1);
    // writes ignored while in reset
    @(negedge clk); ptr = 32'h70; in_block = blk_b; write_enable = 1;
    @(negedge clk); write_enable = 0;
    chk("rst_we_ign", 32'h70, 32'h0, '0, 1);
    chk("rst_x_gone", 32'h10, 32'h0, '0, 0);
    rst_n = 1;
    wr(32'h0000_0073, blk_a);
    chk("post_rst_wr", 32'h73, 32'h1000_0003, blk_a, 1);
    chk("post_rst_5", 32'h50, 32'h0, '0, 1);
    for (int t = 0; t < 20 && q.size() > 0; t++) #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter WORD_SIZE, default 32, word width in bits.
REQ-002 Parameter BLOCK_SIZE, default 16, words per block.
REQ-003 Parameter MEM_BLOCKS, default 1024, number of blocks stored; power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ptr  input  WORD_SIZE  word address.
REQ-007 in_block  input  WORD_SIZE*BLOCK_SIZE  block write data.
REQ-008 out_data  output  WORD_SIZE  word at ptr.
REQ-009 out_block  output  WORD_SIZE*BLOCK_SIZE  whole block containing ptr.
REQ-010 write_enable  input  1  block write strobe.
REQ-011 Positional port order SHALL be ptr, in_block, out_data, out_block, clk, write_enable, rst_n.

Function
REQ-012 Address decode SHALL be: offset = ptr[3:0], block index = ptr[13:4] for defaults (log2(MEM_BLOCKS) bits above offset); upper ptr bits SHALL be ignored, so addresses alias modulo MEM_BLOCKS*BLOCK_SIZE words.
REQ-013 Storage SHALL be MEM_BLOCKS entries of WORD_SIZE*BLOCK_SIZE bits.
REQ-014 Word order within a block SHALL be big-endian: word at offset k occupies bits [(BLOCK_SIZE-k)*WORD_SIZE-1 : (BLOCK_SIZE-1-k)*WORD_SIZE]; offset 0 is the MSB word, offset 15 the LSB word.
REQ-015 out_block SHALL combinationally equal the stored block at the decoded index of ptr (zero read latency).
REQ-016 out_data SHALL combinationally equal the word at the decoded offset of out_block.
REQ-017 On rising clk with rst_n high and write_enable high, the entire block at the decoded index SHALL be replaced by in_block; no partial-word or byte writes.
REQ-018 write_enable low on a rising edge SHALL leave storage unchanged.
REQ-019 Read-during-write: before the edge, outputs show old contents; after the edge, outputs show in_block (write-first visible once stored, no extra cycle).
REQ-020 Changing ptr with no clock edge SHALL update outputs within the same delta/combinational path, with no state change.
REQ-021 Consecutive-cycle writes to same or different blocks SHALL each take effect on their own edge; last write wins for the same block.
REQ-022 Writes to aliased addresses (differing only in ignored bits) SHALL target the same block.
REQ-023 X/Z-free: with defined inputs, outputs SHALL never be X after first reset.

Reset
REQ-024 rst_n low SHALL immediately (no clock) clear every block to all-zeros; out_data and out_block SHALL then read 0 for any ptr.
REQ-025 While rst_n low, write_enable SHALL be ignored at clock edges.
REQ-026 Reset asserted mid-sequence SHALL discard all prior writes; after rst_n rises, first write takes effect on the next rising edge with write_enable high.

Verification
REQ-027 Reset: pulse rst_n low, ptr=0x0000_0123 -> out_block=0, out_data=0.
REQ-028 Block write/read: ptr=0x40, in_block words 0..15 = 0x1000_0000+k, write_enable one cycle -> after edge, ptr=0x40..0x4F gives out_data=0x1000_0000+offset; out_block MSB word = 0x1000_0000.
REQ-029 Enable low: write_enable=0, different in_block at ptr=0x40 across several edges -> contents unchanged from REQ-028.
REQ-030 Aliasing: write all-0xAAAA_AAAA block at ptr=0x0000_4010 -> ptr=0x0000_0010 reads 0xAAAA_AAAA.
REQ-031 Back-to-back: write block A at index 5 then block B at index 5 next cycle -> index 5 reads B; index 6 still 0.
REQ-032 Async reset mid-run: after REQ-028 data, drop rst_n between clock edges -> out_data reads 0 immediately, before the next edge.
